// File: rtl/mult_tree_pipe_if.sv
// Stream interface for mult_tree_pipe: operand-set input channel and result output channel.
// The slave modport is the kernel side; master is the producer/consumer side.
interface mult_tree_pipe_if #(
    parameter int W     = 4,
    parameter int OUT_W = 8
);
    logic             i_valid;
    logic             i_ready;
    logic [W-1:0]     i_a;
    logic [W-1:0]     i_b;
    logic [W-1:0]     i_c;
    logic [W-1:0]     i_d;
    logic             o_valid;
    logic             o_ready;
    logic [OUT_W-1:0] o_result;

    modport slave (
        input  i_valid, i_a, i_b, i_c, i_d, o_ready,
        output i_ready, o_valid, o_result
    );

    modport master (
        output i_valid, i_a, i_b, i_c, i_d, o_ready,
        input  i_ready, o_valid, o_result
    );
endinterface

// File: rtl/mult_tree_pipe.sv
// 3-stage flow-controlled product tree: result = top OUT_W bits of (a*b*b)*(c*d*d).
// Optional half-up rounding with saturation when MULT_TREE_ROUND_EN is defined.
module mult_tree_pipe #(
    parameter int W     = 4,
    parameter int OUT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_tree_pipe_if.slave bus
);
    localparam int PW = 6 * W;
    localparam int HW = 3 * W;

    logic             adv;
    logic             load;
    logic [2:0]       vld_pipe_q, vld_pipe_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [HW-1:0]    aab_q, aab_d, ccd_q, ccd_d;
    logic [PW-1:0]    prod_d;
    logic [OUT_W-1:0] slice_d, rnd_d;
    logic [OUT_W-1:0] res_q, res_d;

    // One enable for every stage: the pipe moves unless a valid result is stuck at the output.
    assign adv          = !vld_pipe_q[2] || bus.o_ready;
    assign bus.i_ready  = adv;
    assign bus.o_valid  = vld_pipe_q[2];
    assign bus.o_result = res_q;

    assign prod_d  = PW'(aab_q) * PW'(ccd_q);
    assign slice_d = OUT_W'(prod_d >> (PW - OUT_W));

`ifdef MULT_TREE_ROUND_EN
    generate
        if (OUT_W < PW) begin : g_rnd
            // Half-up, but an all-ones slice must not wrap to zero.
            always_comb begin
                rnd_d = slice_d;
                if (prod_d[PW-OUT_W-1] && !(&slice_d))
                    rnd_d = slice_d + OUT_W'(1);
            end
        end else begin : g_nornd
            assign rnd_d = slice_d;
        end
    endgenerate
`else
    assign rnd_d = slice_d;
`endif

    always_comb begin
        load       = adv && bus.i_valid;
        vld_pipe_d = vld_pipe_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        aab_d      = aab_q;
        ccd_d      = ccd_q;
        res_d      = res_q;
        if (load) begin
            a_d = bus.i_a;
            b_d = bus.i_b;
            c_d = bus.i_c;
            d_d = bus.i_d;
        end
        if (adv) begin
            vld_pipe_d = {vld_pipe_q[1:0], bus.i_valid};
            aab_d      = HW'(a_q) * HW'(b_q) * HW'(b_q);
            ccd_d      = HW'(c_q) * HW'(d_q) * HW'(d_q);
            res_d      = rnd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            aab_q      <= '0;
            ccd_q      <= '0;
            res_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            aab_q      <= aab_d;
            ccd_q      <= ccd_d;
            res_q      <= res_d;
        end
    end
endmodule

// File: tb/tb_mult_tree_pipe.sv
// Directed bench for mult_tree_pipe (W=4/OUT_W=8 main instance, W=16/OUT_W=1 saturation instance).
// Output transfers are scoreboarded against expected values queued with each input transfer.
module tb_mult_tree_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_tree_pipe_if #(.W(4),  .OUT_W(8)) bus ();
    mult_tree_pipe_if #(.W(16), .OUT_W(1)) sbus ();

    mult_tree_pipe #(.W(4),  .OUT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mult_tree_pipe #(.W(16), .OUT_W(1)) dut_s(.clk(clk), .rst_n(rst_n), .bus(sbus));

`ifdef MULT_TREE_ROUND_EN
    localparam logic [7:0] EXP15 = 8'd174;
`else
    localparam logic [7:0] EXP15 = 8'd173;
`endif

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [7:0] exp_in;
    logic [7:0] q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_res;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference: full product, top byte, optional half-up with saturation.
    function automatic logic [7:0] model(input int a, input int b, input int c, input int d);
        logic [63:0] p;
        logic [7:0]  r;
        p = 64'(a) * 64'(b) * 64'(b) * 64'(c) * 64'(d) * 64'(d);
        r = p[23:16];
`ifdef MULT_TREE_ROUND_EN
        if (p[15] && r != 8'hFF) r = r + 8'd1;
`endif
        return r;
    endfunction

    // Scoreboard: everything is evaluated half a cycle before the edge that acts on it.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", bus.o_result, prev_res);
            if (bus.o_valid && bus.o_ready) begin
                n_out++;
                if (q.size() == 0) chk("extra_out", 1, 0);
                else chk("res", bus.o_result, q.pop_front());
            end
            if (bus.i_valid && bus.i_ready) q.push_back(exp_in);
            prev_stall = bus.o_valid && !bus.o_ready;
            prev_res   = bus.o_result;
        end
    end

    task automatic send(input int a, input int b, input int c, input int d, input logic [7:0] e);
        int n;
        bus.i_a = 4'(a); bus.i_b = 4'(b); bus.i_c = 4'(c); bus.i_d = 4'(d);
        exp_in = e;
        bus.i_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.i_ready && n < 50);
        if (!bus.i_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic iv [0:11];
        logic ov [0:11];
        bus.i_valid = 1'b1;
        bus.i_a = 4'(3); bus.i_b = 4'(7); bus.i_c = 4'(11); bus.i_d = 4'(5);
        bus.o_ready = 1'b1;
        exp_in = 8'd0;
        sbus.i_valid = 1'b1; sbus.o_ready = 1'b1;
        sbus.i_a = 16'hFFFF; sbus.i_b = 16'hFFFF; sbus.i_c = 16'hFFFF; sbus.i_d = 16'hFFFF;

        // Reset held with live stimulus
        repeat (4) @(posedge clk);
        #1;
        chk("rst_ovalid", bus.o_valid, 0);
        chk("rst_result", bus.o_result, 0);
        chk("rst_s_result", sbus.o_result, 0);
        bus.i_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_iready", bus.i_ready, 1);

        // Saturation instance: max operands give slice 1 with round bit 1 -> must stay 1
        repeat (5) @(posedge clk);
        #1;
        chk("sat_valid", sbus.o_valid, 1);
        chk("sat_allones", sbus.o_result, 1);
        sbus.i_a = 16'd1; sbus.i_b = 16'd1; sbus.i_c = 16'd1; sbus.i_d = 16'd1;
        repeat (4) @(posedge clk);
        #1;
        chk("sat_small", sbus.o_result, 0);

        // Latency with 15,15,15,15
        bus.i_a = 4'hF; bus.i_b = 4'hF; bus.i_c = 4'hF; bus.i_d = 4'hF;
        exp_in = EXP15;
        bus.i_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if (n == 0) bus.i_valid = 1'b0;
            n++;
        end while (!bus.o_valid && n < 10);
        chk("latency", n, 3);
        chk("lat_res", bus.o_result, EXP15);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back sets, results 4, 8, 0 on consecutive cycles
        send(8, 8, 8, 8, 8'd4);
        send(9, 9, 9, 9, 8'd8);
        send(0, 15, 15, 15, 8'd0);
        chk("b2b_v0", bus.o_valid, 1);
        chk("b2b_r0", bus.o_result, 4);
        @(posedge clk); #1;
        chk("b2b_v1", bus.o_valid, 1);
        chk("b2b_r1", bus.o_result, 8);
        @(posedge clk); #1;
        chk("b2b_v2", bus.o_valid, 1);
        chk("b2b_r2", bus.o_result, 0);
        @(posedge clk); #1;
        chk("b2b_v3", bus.o_valid, 0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: 10-set stream with a 5-cycle consumer stall
        n = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(i + 3, 15 - i, (3 * i + 1) % 16, 7, model(i + 3, 15 - i, (3 * i + 1) % 16, 7));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.o_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_vld_rdy", {bus.o_valid, bus.i_ready}, 2'b10);
                end
                @(posedge clk); #1;
                bus.o_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("stream_count", n_out - n, 10);
        chk("stream_drained", q.size(), 0);

        // Bubbles: alternating i_valid shows up on o_valid three edges later
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            ov[k] = bus.o_valid;
            iv[k] = (k < 6) && (k % 2 == 0);
            bus.i_a = 4'(k + 1); bus.i_b = 4'd2; bus.i_c = 4'd3; bus.i_d = 4'd1;
            exp_in = model(k + 1, 2, 3, 1);
            bus.i_valid = iv[k];
        end
        for (int k = 0; k < 8; k++) chk($sformatf("bubble_%0d", k), ov[k + 3], iv[k]);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-operation with a stalled result: o_valid drops without a clock edge
        bus.o_ready = 1'b0;
        send(1, 1, 1, 1, model(1, 1, 1, 1));
        n = 0;
        while (!bus.o_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("pre_rst_valid", bus.o_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ovalid", bus.o_valid, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.o_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_idle", bus.o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
